// File: rtl/fixed_encoder_pkg.sv
// Shared constants, order type and helpers for the fixed-predictor encoder.
`timescale 1ns/1ps
package fixed_encoder_pkg;

  localparam int unsigned ORDER_MAX  = 4;
  localparam int unsigned RES_GUARD  = 4;
  localparam int unsigned NUM_ORDERS = ORDER_MAX + 1;

  typedef logic [2:0] order_t;

  // Binomial coefficients of the order 2..4 difference filters.
  localparam int unsigned COEF_2 = 2;
  localparam int unsigned COEF_3 = 3;
  localparam int unsigned COEF_4 = 4;
  localparam int unsigned COEF_6 = 6;

  function automatic order_t clamp_order(input order_t ord);
    return (ord > order_t'(ORDER_MAX)) ? order_t'(ORDER_MAX) : ord;
  endfunction

endpackage

// File: rtl/fixed_predictor_diff.sv
// Combinational fixed-predictor residuals e0..e4 from a sample and its 4-entry history.
`timescale 1ns/1ps
module fixed_predictor_diff
  import fixed_encoder_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic signed [SAMPLE_W-1:0]                         iSample,
  // Entry k-1 holds x[n-k].
  input  logic        [4*SAMPLE_W-1:0]                       iHist,
  output logic        [NUM_ORDERS*(SAMPLE_W+RES_GUARD)-1:0]  oRes
);

  localparam int unsigned RW = SAMPLE_W + RES_GUARD;

  localparam logic signed [RW-1:0] K2 = RW'(COEF_2);
  localparam logic signed [RW-1:0] K3 = RW'(COEF_3);
  localparam logic signed [RW-1:0] K4 = RW'(COEF_4);
  localparam logic signed [RW-1:0] K6 = RW'(COEF_6);

  logic signed [RW-1:0] w_x, w_h1, w_h2, w_h3, w_h4;
  logic signed [RW-1:0] w_e0, w_e1, w_e2, w_e3, w_e4;

  always_comb begin
    w_x  = RW'(iSample);
    w_h1 = RW'($signed(iHist[0*SAMPLE_W +: SAMPLE_W]));
    w_h2 = RW'($signed(iHist[1*SAMPLE_W +: SAMPLE_W]));
    w_h3 = RW'($signed(iHist[2*SAMPLE_W +: SAMPLE_W]));
    w_h4 = RW'($signed(iHist[3*SAMPLE_W +: SAMPLE_W]));

    w_e0 = w_x;
    w_e1 = w_x - w_h1;
    w_e2 = w_x - K2 * w_h1 + w_h2;
    w_e3 = w_x - K3 * w_h1 + K3 * w_h2 - w_h3;
    w_e4 = w_x - K4 * w_h1 + K6 * w_h2 - K4 * w_h3 + w_h4;

    oRes = {w_e4, w_e3, w_e2, w_e1, w_e0};
  end

endmodule

// File: rtl/fixed_encoder_var.sv
// Variable-order fixed-predictor residual encoder with registered, back-pressured output.
// Optional per-order |residual| sums are enabled by defining FIXED_ENCODER_ABS_SUM_EN.
`timescale 1ns/1ps
module fixed_encoder_var
  import fixed_encoder_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16
`ifdef FIXED_ENCODER_ABS_SUM_EN
  ,
  parameter int unsigned ACC_W    = 32
`endif
) (
  input  logic                                iClock,
  input  logic                                iReset,
  input  logic                                iValid,
  input  logic                                iFirst,
  input  logic                                iLast,
  input  logic        [2:0]                   iOrder,
  input  logic signed [SAMPLE_W-1:0]          iSample,
  output logic                                oReady,
  input  logic                                iReady,
  output logic                                oValid,
  output logic signed [SAMPLE_W+RES_GUARD-1:0] oResidual,
  output logic                                oWarmup,
  output logic                                oLast
`ifdef FIXED_ENCODER_ABS_SUM_EN
  ,
  output logic        [NUM_ORDERS*ACC_W-1:0]  oAbsSum,
  output logic                                oSumValid
`endif
);

  localparam int unsigned RW = SAMPLE_W + RES_GUARD;

  logic                          r_valid, r_warmup, r_last;
  logic signed [RW-1:0]          r_res;
  order_t                        r_order, r_warm;
  logic [4*SAMPLE_W-1:0]         r_hist;

  logic                          w_accept;
  order_t                        w_order, w_cnt, w_cnt_next;
  logic [4*SAMPLE_W-1:0]         w_hist;
  logic [NUM_ORDERS*RW-1:0]      w_res;
  logic                          w_warm;
  logic signed [RW-1:0]          w_out;

  fixed_predictor_diff #(
    .SAMPLE_W (SAMPLE_W)
  ) u_pred (
    .iSample (iSample),
    .iHist   (w_hist),
    .oRes    (w_res)
  );

  // A first sample sees a fresh block: new order, cleared history, warm-up restarted.
  always_comb begin
    w_accept   = iValid && oReady;
    w_order    = iFirst ? clamp_order(iOrder) : r_order;
    w_cnt      = iFirst ? order_t'(0) : r_warm;
    w_hist     = iFirst ? '0 : r_hist;
    w_warm     = (w_cnt < w_order);
    w_out      = w_warm ? RW'(iSample) : $signed(w_res[w_order*RW +: RW]);
    w_cnt_next = (w_cnt >= order_t'(ORDER_MAX)) ? order_t'(ORDER_MAX) : w_cnt + order_t'(1);
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_valid  <= 1'b0;
      r_warmup <= 1'b0;
      r_last   <= 1'b0;
      r_res    <= '0;
      r_order  <= '0;
      r_warm   <= '0;
      r_hist   <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_warmup <= w_warm;
      r_last   <= iLast;
      r_res    <= w_out;
      r_order  <= w_order;
      r_warm   <= w_cnt_next;
      r_hist   <= {w_hist[3*SAMPLE_W-1:0], iSample};
    end else if (iReady) begin
      r_valid  <= 1'b0;
    end
  end

  assign oReady    = iReady || !r_valid;
  assign oValid    = r_valid;
  assign oResidual = r_res;
  assign oWarmup   = r_warmup;
  assign oLast     = r_last;

`ifdef FIXED_ENCODER_ABS_SUM_EN
  logic [NUM_ORDERS*ACC_W-1:0] r_acc, r_abs_sum, w_acc_next;
  logic                        r_sum_valid;

  // Saturating per-order accumulation; a first sample restarts every sum.
  always_comb begin
    logic signed [RW-1:0] w_e;
    logic        [RW-1:0] w_mag;
    logic        [ACC_W-1:0] w_base;
    logic        [ACC_W:0]   w_wide;
    w_acc_next = '0;
    for (int k = 0; k < NUM_ORDERS; k++) begin
      w_e    = $signed(w_res[k*RW +: RW]);
      w_mag  = w_e[RW-1] ? RW'(-w_e) : RW'(w_e);
      w_base = iFirst ? '0 : r_acc[k*ACC_W +: ACC_W];
      w_wide = {1'b0, w_base} + (ACC_W+1)'(w_mag);
      w_acc_next[k*ACC_W +: ACC_W] = w_wide[ACC_W] ? '1 : w_wide[ACC_W-1:0];
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_acc       <= '0;
      r_abs_sum   <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= w_accept && iLast;
      if (w_accept) begin
        r_acc <= w_acc_next;
        if (iLast) begin
          r_abs_sum <= w_acc_next;
        end
      end
    end
  end

  assign oAbsSum   = r_abs_sum;
  assign oSumValid = r_sum_valid;
`endif

endmodule
